// File: rtl/seven_color_pkg.sv
// rtl/seven_color_pkg.sv - shared state encoding, RGB bit positions and colour table
package seven_color_pkg;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SHOW = ST_SHOW,
    S_GAP  = ST_GAP
  } state_t;

  // Bit positions of each channel inside the {r,g,b} vector
  localparam int RGB_R = 2;
  localparam int RGB_G = 1;
  localparam int RGB_B = 0;

  localparam logic [2:0] R_BIT = 3'(1 << RGB_R);
  localparam logic [2:0] G_BIT = 3'(1 << RGB_G);
  localparam logic [2:0] B_BIT = 3'(1 << RGB_B);

  // Seven-colour flash table, indexed 1..7
  localparam logic [2:0] COLOR_1 = R_BIT;
  localparam logic [2:0] COLOR_2 = G_BIT;
  localparam logic [2:0] COLOR_3 = B_BIT;
  localparam logic [2:0] COLOR_4 = R_BIT | G_BIT;
  localparam logic [2:0] COLOR_5 = G_BIT | B_BIT;
  localparam logic [2:0] COLOR_6 = R_BIT | B_BIT;
  localparam logic [2:0] COLOR_7 = R_BIT | G_BIT | B_BIT;

  // Colour index to LED drive; index 0 (idle) is dark
  function automatic logic [2:0] color_of(input logic [2:0] idx);
    logic [2:0] c;
    c = 3'b000;
    case (idx)
      3'd1: c = COLOR_1;
      3'd2: c = COLOR_2;
      3'd3: c = COLOR_3;
      3'd4: c = COLOR_4;
      3'd5: c = COLOR_5;
      3'd6: c = COLOR_6;
      3'd7: c = COLOR_7;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seven_color_sequencer_if.sv
// rtl/seven_color_sequencer_if.sv - control/LED bundle between board control and the sequencer
interface seven_color_sequencer_if;
  logic       start;
  logic       stop;
  logic       loop;
`ifdef SEVEN_COLOR_PWM_EN
  logic [3:0] duty;
`endif
  logic [2:0] rgb;
  logic [2:0] color_idx;
  logic       busy;
  logic       done;

  // Board-level controller side
  modport master (
    output start, stop, loop,
`ifdef SEVEN_COLOR_PWM_EN
    output duty,
`endif
    input  rgb, color_idx, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, stop, loop,
`ifdef SEVEN_COLOR_PWM_EN
    input  duty,
`endif
    output rgb, color_idx, busy, done
  );
endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk into a one-cycle tick every CLK_DIV enabled cycles
module tick_prescaler #(
  parameter int CLK_DIV = 500,
  parameter int CNT_W   = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = enable && (cnt_q == LAST);

  // Count only while enabled, wrap on tick, restart from zero on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seven_color_sequencer.sv
// rtl/seven_color_sequencer.sv - seven-colour RGB flash sequencer; SEVEN_COLOR_PWM_EN adds duty-cycle dimming
module seven_color_sequencer
  import seven_color_pkg::*;
#(
  parameter int CLK_DIV     = 500,
  parameter int DWELL_TICKS = 4,
  parameter int GAP_TICKS   = 1,
  parameter int CNT_W       = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_color_sequencer_if.slave  bus
);

  localparam int MAX_TICKS = (DWELL_TICKS > GAP_TICKS) ? DWELL_TICKS : GAP_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          done_q, done_d;
  logic          clear;
  logic          seq_end;
  logic          tick;
  logic [2:0]    lit_mask;

  tick_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .enable (state_q != S_IDLE),
    .tick   (tick)
  );

`ifdef SEVEN_COLOR_PWM_EN
  logic [3:0] pwm_q;

  // Free-running PWM phase; lit channels pass only while phase is below duty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 4'd0;
    else        pwm_q <= pwm_q + 4'd1;
  end

  assign lit_mask = (pwm_q < bus.duty) ? 3'b111 : 3'b000;
`else
  assign lit_mask = 3'b111;
`endif

  // State, colour index, tick count and registered LED outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      tcnt_q  <= '0;
      rgb_q   <= 3'b000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      rgb_q   <= rgb_d;
      done_q  <= done_d;
    end
  end

  // Next state: dwell/gap tick counting, end-of-colour advance, stop override
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    seq_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SHOW;
          idx_d   = 3'd1;
          tcnt_d  = '0;
          clear   = 1'b1;
        end
      end
      S_SHOW: begin
        if (tick) begin
          if (tcnt_q == DWELL_LAST) begin
            tcnt_d = '0;
            clear  = 1'b1;
            if (GAP_TICKS == 0) seq_end = 1'b1;
            else                state_d = S_GAP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (tcnt_q == GAP_LAST) begin
            tcnt_d  = '0;
            clear   = 1'b1;
            seq_end = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
        tcnt_d  = '0;
      end
    endcase

    // End of a colour slot: advance, wrap when looping, or finish
    if (seq_end) begin
      if (idx_q != 3'd7) begin
        state_d = S_SHOW;
        idx_d   = idx_q + 3'd1;
      end else if (bus.loop) begin
        state_d = S_SHOW;
        idx_d   = 3'd1;
      end else begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
        done_d  = 1'b1;
      end
    end

    // Abort has priority over everything, including a same-cycle start
    if (bus.stop) begin
      state_d = S_IDLE;
      idx_d   = 3'd0;
      tcnt_d  = '0;
      done_d  = 1'b0;
      clear   = 1'b1;
    end

    rgb_d = (state_d == S_SHOW) ? (color_of(idx_d) & lit_mask) : 3'b000;
  end

  assign bus.rgb       = rgb_q;
  assign bus.color_idx = idx_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;

endmodule
